// File: rtl/piso_pkg.sv
// piso_pkg -- shared types and constants for the parallel-in/serial-out
// transmitter.
//   state_t       : transmitter FSM state (IDLE, SHIFT)
//   DEFAULT_WIDTH : default parallel word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_hold_reg.sv
// piso_hold_reg -- one-entry holding register with full flag.
// Parks the next word while the shifter is still busy with the current one.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : capture wr_data and mark the entry full
//   wr_data  : word to park
//   rd_en    : entry consumed by the shifter, mark it empty
//   data     : parked word
//   full     : entry occupied
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // The parent never writes and reads in the same cycle (writes need the
  // entry empty, reads need it full), so the priority below is only a guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (rd_en) begin
      full <= 1'b0;
    end else if (wr_en) begin
      data <= wr_data;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in/serial-out transmitter with a one-word holding
// register so that back-to-back words are sent with no idle cycle between
// frames.
// Parameters:
//   WIDTH     : parallel word width (>= 2)
//   MSB_FIRST : 1 = send bit WIDTH-1 first, 0 = send bit 0 first
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : upstream word valid
//   in_data     : parallel word, taken when in_valid & in_ready
//   in_ready    : a word can be accepted this cycle
//   ser_out     : serial bit (forced to 0 when ser_valid is low)
//   ser_valid   : ser_out carries a frame bit
//   frame_start : high on the first bit of each frame
//   busy        : shifter or holding register occupied
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             fire;
  logic             last_bit;
  logic             hold_wr;
  logic             hold_rd;

  // Ready depends only on the holding register, never on in_valid.
  assign in_ready = !hold_full;
  assign fire     = in_valid && in_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // A word arriving mid-frame is parked; the parked word is pulled into the
  // shifter on the last bit of the current frame.
  assign hold_wr = fire && (state == SHIFT) && !last_bit;
  assign hold_rd = (state == SHIFT) && last_bit && hold_full;

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (hold_wr),
    .wr_data(in_data),
    .rd_en  (hold_rd),
    .data   (hold_data),
    .full   (hold_full)
  );

  // Shift direction follows the bit order so the outgoing bit always sits at
  // the end being presented on ser_out.
  always_comb begin
    shifted = '0;
    if (MSB_FIRST != 0) begin
      shifted = shreg << 1;
    end else begin
      shifted = shreg >> 1;
    end
  end

  // Transmitter FSM. On the last bit the next frame is loaded from the
  // holding register, or straight from in_data if nothing is parked, so
  // consecutive frames run without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            shreg <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            cnt <= '0;
            if (hold_full) begin
              shreg <= hold_data;
            end else if (fire) begin
              shreg <= in_data;
            end else begin
              shreg <= shifted;
              state <= IDLE;
            end
          end else begin
            shreg <= shifted;
            cnt   <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          shreg <= '0;
        end
      endcase
    end
  end

  assign ser_valid   = (state == SHIFT);
  assign ser_out     = ser_valid && ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
  assign frame_start = ser_valid && (cnt == '0);
  assign busy        = ser_valid || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- scoreboard bench for piso_tx. Two instances (MSB-first and
// LSB-first) receive identical stimulus. Every accepted word expands into
// its WIDTH expected serial bits in a per-instance queue; a monitor on the
// falling edge pops and compares whenever ser_valid is high, and derives the
// expected in_ready/busy/ser_valid from how many bits are still pending.
// A behavioural left-shift SIPO on the MSB-first stream must hold each word
// after its last bit.
module tb_piso_tx;

  localparam int W = 4;

  typedef struct packed {
    logic         b;
    logic         first;
    logic         last;
    logic [W-1:0] word;
  } ent_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic m_ready, m_ser, m_valid, m_fs, m_busy;
  logic l_ready, l_ser, l_valid, l_fs, l_busy;

  ent_t         q_msb[$];
  ent_t         q_lsb[$];
  logic [W-1:0] sipo;
  logic         sipo_pending;
  logic [W-1:0] sipo_expect;

  int checks;
  int errors;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (m_ready),
    .ser_out    (m_ser),
    .ser_valid  (m_valid),
    .frame_start(m_fs),
    .busy       (m_busy)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (l_ready),
    .ser_out    (l_ser),
    .ser_valid  (l_valid),
    .frame_start(l_fs),
    .busy       (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream receiver: left-shift SIPO enabled by ser_valid.
  always @(posedge clk) begin
    if (m_valid) sipo <= {sipo[W-2:0], m_ser};
  end

  // Rising edge: record accepted words as expected bit sequences.
  // Falling edge: compare DUT outputs against the pending expectations.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (!rst) begin
        if (in_valid && m_ready)
          for (int k = 0; k < W; k++)
            q_msb.push_back('{in_data[W-1-k], k == 0, k == W-1, in_data});
        if (in_valid && l_ready)
          for (int k = 0; k < W; k++)
            q_lsb.push_back('{in_data[k], k == 0, k == W-1, in_data});
      end
    end else if (rst) begin
      q_msb.delete();
      q_lsb.delete();
      sipo_pending = 1'b0;
      checkOutput("rst_msb_ser_valid", m_valid, 0);
      checkOutput("rst_msb_ser_out", m_ser, 0);
      checkOutput("rst_msb_in_ready", m_ready, 1);
      checkOutput("rst_msb_busy", m_busy, 0);
      checkOutput("rst_lsb_ser_valid", l_valid, 0);
      checkOutput("rst_lsb_frame_start", l_fs, 0);
    end else begin
      ent_t e;
      if (sipo_pending) begin
        checkOutput("sipo_word", sipo, sipo_expect);
        sipo_pending = 1'b0;
      end
      checkOutput("msb_in_ready", m_ready, q_msb.size() <= W);
      checkOutput("msb_busy", m_busy, q_msb.size() != 0);
      checkOutput("msb_ser_valid", m_valid, q_msb.size() != 0);
      if (m_valid && q_msb.size() != 0) begin
        e = q_msb.pop_front();
        checkOutput("msb_ser_out", m_ser, e.b);
        checkOutput("msb_frame_start", m_fs, e.first);
        if (e.last) begin
          sipo_pending = 1'b1;
          sipo_expect  = e.word;
        end
      end else begin
        checkOutput("msb_frame_start_idle", m_fs, 0);
      end
      checkOutput("lsb_in_ready", l_ready, q_lsb.size() <= W);
      checkOutput("lsb_busy", l_busy, q_lsb.size() != 0);
      checkOutput("lsb_ser_valid", l_valid, q_lsb.size() != 0);
      if (l_valid && q_lsb.size() != 0) begin
        e = q_lsb.pop_front();
        checkOutput("lsb_ser_out", l_ser, e.b);
        checkOutput("lsb_frame_start", l_fs, e.first);
      end else begin
        checkOutput("lsb_frame_start_idle", l_fs, 0);
      end
    end
  end

  // Offer a word from the next falling edge until it is accepted, then drop
  // in_valid just after the accepting rising edge.
  task automatic applyStimulus(input logic [W-1:0] word);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = word;
    while (!m_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!m_ready) checkOutput("send_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((q_msb.size() != 0 || q_lsb.size() != 0 || m_busy || l_busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("drain_timeout", cyc < 200, 1);
    idleCycles(2);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    sipo_pending = 1'b0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", m_ready, 1);
    checkOutput("reset_busy", m_busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single word, then idle.
    applyStimulus(4'b1011);
    drain();
    checkOutput("single_busy_after", m_busy, 0);

    // Back-to-back: second word parked during the first frame.
    applyStimulus(4'hA);
    applyStimulus(4'h5);
    #1 checkOutput("b2b_in_ready_held", m_ready, 0);
    drain();

    // Bypass: word offered on the last-bit cycle with nothing parked.
    applyStimulus(4'hC);
    idleCycles(3);
    applyStimulus(4'h3);
    drain();

    // LSB-first single word.
    applyStimulus(4'b0001);
    drain();

    // Reset mid-frame with a word parked.
    applyStimulus(4'hF);
    applyStimulus(4'h9);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_ser_valid", m_valid, 0);
    checkOutput("midrst_busy", m_busy, 0);
    checkOutput("midrst_in_ready", m_ready, 1);
    checkOutput("midrst_lsb_busy", l_busy, 0);
    idleCycles(2);
    #2 rst = 1'b0;
    idleCycles(6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
